// File: rtl/punc_core_seq_if.sv
// rtl/punc_core_seq_if.sv - memory request/acknowledge bus of the punc_core_seq sequencer
interface punc_core_seq_if #(
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_ack;
   logic [15:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/punc_core_seq.sv
// rtl/punc_core_seq.sv - multi-cycle LC3-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer
module punc_core_seq #(
   parameter int          ADDR_W   = 16,
   parameter logic [15:0] RESET_PC = 16'h3000,
   parameter int          NUM_REGS = 8
) (
   input  logic               clk,
   input  logic               rst,
   punc_core_seq_if.master    mem,
   input  logic [2:0]         rf_debug_addr,
   output logic [15:0]        rf_debug_data,
   output logic [15:0]        pc_debug_data,
   output logic [2:0]         nzp,
   output logic               halted
);
   if (NUM_REGS != 8) begin : g_bad_num_regs
      $error("punc_core_seq: NUM_REGS must be 8");
   end
   if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
      $error("punc_core_seq: ADDR_W must be 1..16");
   end

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [3:0] OP_BR   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_LEA  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [15:0]       rf_q [NUM_REGS];
   logic [2:0]        nzp_q, nzp_d;
   logic [15:0]       a_q, a_d;
   logic [15:0]       b_q, b_d;
   logic [ADDR_W-1:0] ea_q, ea_d;
   logic [15:0]       mdr_q, mdr_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;

   logic              rf_we;
   logic [15:0]       rf_wdata;
   logic [3:0]        opcode;
   logic [15:0]       imm5_sx, off9_sx, pc_off9;
   logic              mem_done;

   function automatic logic [2:0] nzp_of(input logic [15:0] v);
      if (v[15])
         return 3'b100;
      else if (v == 16'h0000)
         return 3'b010;
      return 3'b001;
   endfunction

   assign opcode   = ir_q[15:12];
   assign imm5_sx  = {{11{ir_q[4]}}, ir_q[4:0]};
   assign off9_sx  = {{7{ir_q[8]}}, ir_q[8:0]};
   assign pc_off9  = 16'(pc_q) + off9_sx;
   // An ack only counts against an outstanding request
   assign mem_done = req_q && mem.mem_ack;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      nzp_d    = nzp_q;
      a_d      = a_q;
      b_d      = b_q;
      ea_d     = ea_q;
      mdr_d    = mdr_q;
      wdata_d  = wdata_q;
      rf_we    = 1'b0;
      rf_wdata = 16'h0000;
      case (state_q)
         S_FETCH: begin
            if (mem_done) begin
               ir_d    = mem.mem_rdata;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = rf_q[ir_q[8:6]];
            b_d     = ir_q[5] ? imm5_sx : rf_q[ir_q[2:0]];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode)
               OP_ADD: begin
                  rf_we    = 1'b1;
                  rf_wdata = a_q + b_q;
                  nzp_d    = nzp_of(a_q + b_q);
               end
               OP_AND: begin
                  rf_we    = 1'b1;
                  rf_wdata = a_q & b_q;
                  nzp_d    = nzp_of(a_q & b_q);
               end
               OP_NOT: begin
                  rf_we    = 1'b1;
                  rf_wdata = ~a_q;
                  nzp_d    = nzp_of(~a_q);
               end
               OP_LEA: begin
                  rf_we    = 1'b1;
                  rf_wdata = pc_off9;
               end
               OP_BR: begin
                  if ((ir_q[11:9] & nzp_q) != 3'b000)
                     pc_d = ADDR_W'(pc_off9);
               end
               OP_JMP: pc_d = ADDR_W'(a_q);
               OP_LD, OP_ST: begin
                  ea_d    = ADDR_W'(pc_off9);
                  wdata_d = rf_q[ir_q[11:9]];
                  state_d = S_MEM;
               end
               OP_HALT: state_d = S_HALT;
               default: ;
            endcase
         end
         S_MEM: begin
            if (mem_done) begin
               if (opcode == OP_LD) begin
                  mdr_d   = mem.mem_rdata;
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            rf_we    = 1'b1;
            rf_wdata = mdr_q;
            nzp_d    = nzp_of(mdr_q);
            state_d  = S_FETCH;
         end
         S_HALT:  ;
         default: state_d = S_FETCH;
      endcase
   end

   // Bus outputs are registered from the next state so a request starts the cycle the state is entered
   always_comb begin
      req_d  = (state_d == S_FETCH) || (state_d == S_MEM);
      we_d   = (state_d == S_MEM) && (opcode == OP_ST);
      addr_d = (state_d == S_MEM) ? ea_d : pc_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= ADDR_W'(RESET_PC);
         ir_q    <= 16'h0000;
         nzp_q   <= 3'b010;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         ea_q    <= '0;
         mdr_q   <= 16'h0000;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 16'h0000;
         for (int i = 0; i < NUM_REGS; i++)
            rf_q[i] <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         nzp_q   <= nzp_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ea_q    <= ea_d;
         mdr_q   <= mdr_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         if (rf_we)
            rf_q[ir_q[11:9]] <= rf_wdata;
      end
   end

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   assign rf_debug_data = rf_q[rf_debug_addr];
   assign pc_debug_data = 16'(pc_q);
   assign nzp           = nzp_q;
   assign halted        = (state_q == S_HALT);
endmodule

// File: tb/tb_punc_core_seq.sv
// tb/tb_punc_core_seq.sv - self-checking bench for punc_core_seq against an instruction-level model
module tb_punc_core_seq;
   localparam int ADDR_W = 16;

   typedef struct {
      int          t;
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
      logic [15:0] pc;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  rf_debug_addr = 3'd0;
   logic [15:0] rf_debug_data;
   logic [15:0] pc_debug_data;
   logic [2:0]  nzp;
   logic        halted;

   punc_core_seq_if #(.ADDR_W(ADDR_W)) mem ();

   punc_core_seq #(.ADDR_W(ADDR_W), .RESET_PC(16'h3000), .NUM_REGS(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem           (mem),
      .rf_debug_addr (rf_debug_addr),
      .rf_debug_data (rf_debug_data),
      .pc_debug_data (pc_debug_data),
      .nzp           (nzp),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          cycle = 0;
   logic [15:0] tb_mem [0:65535];
   logic [15:0] m_mem  [0:65535];
   logic [15:0] m_reg  [0:7];
   logic [15:0] m_pc;
   logic [2:0]  m_nzp;
   req_t        log_q[$];
   req_t        exp_q[$];
   int          base_delay = 0;
   logic        slow_en = 1'b0;
   logic [15:0] slow_addr = 16'h0000;
   int          slow_delay = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int delay_of(input logic [15:0] a);
      return (slow_en && a == slow_addr) ? slow_delay : base_delay;
   endfunction

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory side: logs each new request, checks hold stability, acks after the configured wait
   initial begin : bus_side
      int          waitc;
      logic        prev_req;
      logic        prev_we;
      logic [15:0] prev_addr;
      req_t        r;
      waitc = 0;
      prev_req = 1'b0;
      prev_we = 1'b0;
      prev_addr = 16'h0000;
      mem.mem_ack = 1'b0;
      mem.mem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem.mem_ack = 1'b0;
            waitc = 0;
            prev_req = 1'b0;
         end else begin
            if (mem.mem_req) begin
               if (!prev_req || mem.mem_ack) begin
                  r.t = cycle;
                  r.addr = mem.mem_addr;
                  r.we = mem.mem_we;
                  r.wdata = mem.mem_wdata;
                  r.pc = pc_debug_data;
                  log_q.push_back(r);
                  waitc = 0;
               end else begin
                  check("hold_addr", mem.mem_addr, prev_addr);
                  check("hold_we", mem.mem_we, prev_we);
               end
               if (waitc >= delay_of(mem.mem_addr)) begin
                  mem.mem_ack = 1'b1;
                  if (mem.mem_we)
                     tb_mem[mem.mem_addr] = mem.mem_wdata;
                  else
                     mem.mem_rdata = tb_mem[mem.mem_addr];
               end else begin
                  mem.mem_ack = 1'b0;
                  waitc++;
               end
            end else begin
               mem.mem_ack = 1'b0;
            end
            prev_req = mem.mem_req;
            prev_we = mem.mem_we;
            prev_addr = mem.mem_addr;
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) begin
         tb_mem[i] = 16'h0000;
         m_mem[i] = 16'h0000;
      end
   endtask

   task automatic put(input logic [15:0] a, input logic [15:0] v);
      tb_mem[a] = v;
      m_mem[a] = v;
   endtask

   function automatic logic [15:0] sx(input int v, input int bits);
      if (v >= (1 << (bits - 1)))
         return 16'(v - (1 << bits));
      return 16'(v);
   endfunction

   function automatic void set_reg(input int d, input logic [15:0] v);
      m_reg[d] = v;
      if (v == 16'h0000)
         m_nzp = 3'b010;
      else if (v >= 16'h8000)
         m_nzp = 3'b100;
      else
         m_nzp = 3'b001;
   endfunction

   function automatic void push_exp(input logic [15:0] a, input logic w, input logic [15:0] d, input int gap);
      req_t e;
      e.t = gap;
      e.addr = a;
      e.we = w;
      e.wdata = d;
      e.pc = 16'h0000;
      exp_q.push_back(e);
   endfunction

   // Instruction-level interpreter; e.t holds the expected cycle gap from the previous request
   task automatic model_run();
      logic [15:0] pc, ir, ea, op2;
      int          gap;
      int          dr, s1;
      bit          done;
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_nzp = 3'b010;
      pc = 16'h3000;
      gap = -1;
      done = 1'b0;
      exp_q.delete();
      for (int n = 0; n < 200 && !done; n++) begin
         ir = m_mem[pc];
         push_exp(pc, 1'b0, 16'h0000, gap);
         gap = 3 + delay_of(pc);
         pc = pc + 16'd1;
         dr = int'(ir[11:9]);
         s1 = int'(ir[8:6]);
         op2 = ir[5] ? sx(int'(ir[4:0]), 5) : m_reg[ir[2:0]];
         case (ir[15:12])
            4'h1: set_reg(dr, m_reg[s1] + op2);
            4'h5: set_reg(dr, m_reg[s1] & op2);
            4'h9: set_reg(dr, ~m_reg[s1]);
            4'hE: m_reg[dr] = pc + sx(int'(ir[8:0]), 9);
            4'h0: if ((ir[11:9] & m_nzp) != 3'b000) pc = pc + sx(int'(ir[8:0]), 9);
            4'hC: pc = m_reg[s1];
            4'h2: begin
               ea = pc + sx(int'(ir[8:0]), 9);
               push_exp(ea, 1'b0, 16'h0000, gap);
               gap = 2 + delay_of(ea);
               set_reg(dr, m_mem[ea]);
            end
            4'h3: begin
               ea = pc + sx(int'(ir[8:0]), 9);
               push_exp(ea, 1'b1, m_reg[dr], gap);
               m_mem[ea] = m_reg[dr];
               gap = 1 + delay_of(ea);
            end
            4'hF: done = 1'b1;
            default: ;
         endcase
      end
      m_pc = pc;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_pc", pc_debug_data, 16'h3000);
      check("rst_nzp", nzp, 3'b010);
      check("rst_req", mem.mem_req, 1'b0);
      check("rst_halted", halted, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      log_q.delete();
   endtask

   task automatic wait_halt(input string tag);
      int n;
      n = 0;
      while (!halted && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(tag, halted, 1'b1);
   endtask

   task automatic compare_run(input string pre);
      int n;
      check({pre, "_nreq"}, log_q.size(), exp_q.size());
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", pre, i), log_q[i].addr, exp_q[i].addr);
         check($sformatf("%s_we%0d", pre, i), log_q[i].we, exp_q[i].we);
         if (exp_q[i].we)
            check($sformatf("%s_wdata%0d", pre, i), log_q[i].wdata, exp_q[i].wdata);
         if (i > 0)
            check($sformatf("%s_gap%0d", pre, i), log_q[i].t - log_q[i-1].t, exp_q[i].t);
      end
      for (int r = 0; r < 8; r++) begin
         rf_debug_addr = 3'(r);
         #1;
         check($sformatf("%s_R%0d", pre, r), rf_debug_data, m_reg[r]);
      end
      check({pre, "_pc"}, pc_debug_data, m_pc);
      check({pre, "_nzp"}, nzp, m_nzp);
   endtask

   task automatic run_program(input string pre);
      apply_reset();
      model_run();
      wait_halt({pre, "_halt"});
      compare_run(pre);
   endtask

   task automatic gen_program();
      logic [2:0]  dr, s1, s2;
      logic [4:0]  i5;
      logic [15:0] ins;
      int          sel;
      clear_mem();
      for (int a = 16'h3040; a < 16'h3200; a++) put(16'(a), 16'($urandom));
      for (int n = 0; n < 24; n++) begin
         dr = 3'($urandom);
         s1 = 3'($urandom);
         s2 = 3'($urandom);
         i5 = 5'($urandom);
         sel = $urandom_range(0, 11);
         case (sel)
            0, 1:    ins = {4'h1, dr, s1, 1'b1, i5};
            2:       ins = {4'h1, dr, s1, 3'b000, s2};
            3:       ins = {4'h5, dr, s1, 1'b1, i5};
            4:       ins = {4'h5, dr, s1, 3'b000, s2};
            5:       ins = {4'h9, dr, s1, 6'h3f};
            6:       ins = {4'hE, dr, 9'($urandom)};
            7:       ins = {4'h0, 3'($urandom), 9'($urandom_range(0, 2))};
            8:       ins = {4'h2, dr, 9'($urandom_range(64, 200))};
            9:       ins = {4'h3, dr, 9'($urandom_range(64, 200))};
            10:      ins = {4'hD, 12'($urandom)};
            default: ins = {4'h4, 12'($urandom)};
         endcase
         put(16'h3000 + 16'(n), ins);
      end
      for (int n = 24; n < 28; n++) put(16'h3000 + 16'(n), 16'hF025);
   endtask

   initial begin
      int n;
      int wr_cnt;
      // ADD immediate, zero-wait
      clear_mem();
      base_delay = 0;
      put(16'h3000, 16'h1261);
      put(16'h3001, 16'hF025);
      run_program("add");
      check("add_first_is_read", log_q.size() >= 2, 1'b1);
      if (log_q.size() >= 2) begin
         check("add_first_addr", log_q[0].addr, 16'h3000);
         check("add_first_we", log_q[0].we, 1'b0);
         check("add_fetch_gap", log_q[1].t - log_q[0].t, 3);
         check("add_pc_next", log_q[1].pc, 16'h3001);
      end
      rf_debug_addr = 3'd1;
      #1;
      check("add_R1", rf_debug_data, 16'h0001);
      check("add_nzp", nzp, 3'b001);

      // LD with three wait cycles on the data access
      clear_mem();
      put(16'h3000, 16'h2402);
      put(16'h3001, 16'hF025);
      put(16'h3003, 16'h8000);
      slow_en = 1'b1;
      slow_addr = 16'h3003;
      slow_delay = 3;
      run_program("ld");
      rf_debug_addr = 3'd2;
      #1;
      check("ld_R2", rf_debug_data, 16'h8000);
      check("ld_nzp", nzp, 3'b100);
      check("ld_len", log_q.size(), 3);
      if (log_q.size() >= 3) begin
         check("ld_data_addr", log_q[1].addr, 16'h3003);
         check("ld_wb_gap", log_q[2].t - log_q[1].t, 5);
      end
      slow_en = 1'b0;

      // BRz taken from the reset flags
      clear_mem();
      put(16'h3000, 16'h0402);
      put(16'h3001, 16'hF025);
      put(16'h3003, 16'hF025);
      run_program("brt");
      if (log_q.size() >= 2) check("brt_target", log_q[1].addr, 16'h3003);

      // BRz not taken after a positive result
      clear_mem();
      put(16'h3000, 16'h1261);
      put(16'h3001, 16'h0402);
      put(16'h3002, 16'hF025);
      put(16'h3004, 16'hF025);
      run_program("brn");
      if (log_q.size() >= 3) check("brn_fallthru", log_q[2].addr, 16'h3002);

      // ST of a loaded value, then HALT
      clear_mem();
      put(16'h3000, 16'h2603);
      put(16'h3001, 16'h3601);
      put(16'h3002, 16'hF025);
      put(16'h3004, 16'hBEEF);
      run_program("st");
      wr_cnt = 0;
      foreach (log_q[i]) if (log_q[i].we) wr_cnt++;
      check("st_write_count", wr_cnt, 1);
      check("st_mem_word", tb_mem[16'h3003], 16'hBEEF);
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         check("halt_idle", {halted, mem.mem_req}, 2'b10);
      end

      // LEA + JMP + NOT
      clear_mem();
      put(16'h3000, 16'hE802);
      put(16'h3001, 16'hC100);
      put(16'h3002, 16'hF025);
      put(16'h3003, 16'h9B3F);
      put(16'h3004, 16'hF025);
      run_program("jmp");

      for (int r = 0; r < 8; r++) begin
         gen_program();
         base_delay = r % 3;
         run_program($sformatf("rnd%0d", r));
      end
      base_delay = 0;

      // Reset while a load is waiting for its ack
      clear_mem();
      put(16'h3000, 16'h1265);
      put(16'h3001, 16'h2401);
      slow_en = 1'b1;
      slow_addr = 16'h3003;
      slow_delay = 1000000;
      apply_reset();
      n = 0;
      while (!(mem.mem_req && mem.mem_addr == 16'h3003) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rld_reach_mem", mem.mem_req && mem.mem_addr == 16'h3003, 1'b1);
      repeat (3) @(negedge clk);
      rf_debug_addr = 3'd1;
      #1;
      check("rld_R1_before", rf_debug_data, 16'h0005);
      #1;
      rst = 1'b1;
      #1;
      check("rld_req_drop", mem.mem_req, 1'b0);
      check("rld_R1_cleared", rf_debug_data, 16'h0000);
      check("rld_pc", pc_debug_data, 16'h3000);
      slow_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      log_q.delete();
      rst = 1'b0;
      n = 0;
      while (log_q.size() == 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("rld_refetch_seen", log_q.size() > 0, 1'b1);
      if (log_q.size() > 0) begin
         check("rld_refetch_addr", log_q[0].addr, 16'h3000);
         check("rld_refetch_we", log_q[0].we, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
